// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: command bytes, FSM states
// and load targets.
package riscv_loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } state_t;

    typedef enum logic {
        TGT_IMEM,
        TGT_DMEM
    } target_t;

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input and memory-write bus of the RAM loader. The loader is the
// slave side; the byte source / memory side uses the master modport.
interface ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  fetch_ram_load;
    logic                  mem_ram_load;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, fetch_ram_load, mem_ram_load
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, fetch_ram_load, mem_ram_load
    );
endinterface

// File: rtl/ram_loader_byte_packer.sv
// Little-endian 4-byte word assembler: byte k lands in bits [8k+7:8k]; done
// pulses for one cycle after the fourth byte, alongside the completed word.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        last,
    output logic        done
);
    logic [1:0] idx;

    assign last = (idx == 2'd3);

    // NOTE: the word register is reset too, because wr_data must read 0 out of
    // reset and a partial word must never survive a mid-packet reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx  <= 2'd0;
            word <= 32'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_en) begin
                word[{idx, 3'b000} +: 8] <= in_byte;
                idx                      <= idx + 2'd1;
                done                     <= last;
            end
        end
    end
endmodule

// File: rtl/ram_loader.sv
// Boot-time loader: parses header/count/word packets from a byte stream,
// writes instruction or data memory, then releases the core from reset.
module ram_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  CMD_IMEM   = riscv_loader_pkg::CMD_IMEM,
    parameter logic [7:0]  CMD_DMEM   = riscv_loader_pkg::CMD_DMEM,
    parameter logic [7:0]  CMD_RUN    = riscv_loader_pkg::CMD_RUN
) (
    input  logic         clock,
    input  logic         reset,
    ram_loader_if.slave  bus,
    output logic         core_hold,
    output logic         error
);
    import riscv_loader_pkg::*;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t                state;
    target_t               target;
    logic [15:0]           count;
    logic [ADDR_WIDTH:0]   word_idx;
    logic [ADDR_WIDTH:0]   next_idx;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  in_ready_q;
    logic                  fetch_q;
    logic                  mem_q;
    logic [15:0]           count_in;
    logic                  xfer;
    logic                  last_word;
    logic [31:0]           packed_word;
    logic                  pack_last;
    logic                  pack_done;

    assign xfer      = bus.in_valid && in_ready_q;
    assign count_in  = {bus.in_data, count[7:0]};
    assign next_idx  = word_idx + (ADDR_WIDTH + 1)'(1);
    assign last_word = (16'(next_idx) == count);

    byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .in_en   (xfer && (state == ST_DATA)),
        .in_byte (bus.in_data),
        .word    (packed_word),
        .last    (pack_last),
        .done    (pack_done)
    );

    assign bus.in_ready       = in_ready_q;
    assign bus.wr_en          = pack_done;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = packed_word;
    assign bus.fetch_ram_load = fetch_q;
    assign bus.mem_ram_load   = mem_q;

    // NOTE: all state and outputs are registered with non-blocking assignments
    // so every output changes only on the clock edge after its cause.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            target     <= TGT_IMEM;
            count      <= 16'd0;
            word_idx   <= '0;
            wr_addr_q  <= '0;
            in_ready_q <= 1'b1;
            fetch_q    <= 1'b0;
            mem_q      <= 1'b0;
            core_hold  <= 1'b1;
            error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (xfer) begin
                    if (bus.in_data == CMD_IMEM) begin
                        target <= TGT_IMEM;
                        state  <= ST_CNT_LO;
                    end else if (bus.in_data == CMD_DMEM) begin
                        target <= TGT_DMEM;
                        state  <= ST_CNT_LO;
                    end else if (bus.in_data == CMD_RUN) begin
                        state      <= ST_RUN;
                        in_ready_q <= 1'b0;
                        core_hold  <= 1'b0;
                    end else begin
                        state      <= ST_ERR;
                        in_ready_q <= 1'b0;
                        error      <= 1'b1;
                    end
                end
                ST_CNT_LO: if (xfer) begin
                    count[7:0] <= bus.in_data;
                    state      <= ST_CNT_HI;
                end
                ST_CNT_HI: if (xfer) begin
                    count[15:8] <= bus.in_data;
                    word_idx    <= '0;
                    if (count_in == 16'd0) begin
                        state <= ST_IDLE;
                    end else if ({1'b0, count_in} > MAX_WORDS) begin
                        state      <= ST_ERR;
                        in_ready_q <= 1'b0;
                        error      <= 1'b1;
                    end else begin
                        state   <= ST_DATA;
                        fetch_q <= (target == TGT_IMEM);
                        mem_q   <= (target == TGT_DMEM);
                    end
                end
                ST_DATA: if (xfer && pack_last) begin
                    state      <= ST_WRITE;
                    in_ready_q <= 1'b0;
                    wr_addr_q  <= word_idx[ADDR_WIDTH-1:0];
                end
                ST_WRITE: begin
                    word_idx   <= next_idx;
                    in_ready_q <= 1'b1;
                    if (last_word) begin
                        state   <= ST_IDLE;
                        fetch_q <= 1'b0;
                        mem_q   <= 1'b0;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_RUN: state <= ST_RUN;
                ST_ERR: state <= ST_ERR;
                default: begin
                    state      <= ST_ERR;
                    in_ready_q <= 1'b0;
                    fetch_q    <= 1'b0;
                    mem_q      <= 1'b0;
                    error      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Boot-time loader that sits directly upstream of the Riscv core and drives its fetch_ram_load / mem_ram_load inputs.
- Accepts a byte stream over a valid/ready handshake and parses command packets.
- Writes 32-bit words into instruction memory or data memory, then releases the core to run.
- Replaces backdoor $readmemh preloading, so programs and data reach memory through a synthesizable path.

Parameters:
- ADDR_WIDTH, 10, word-address width of each target memory (max 1024 words).
- CMD_IMEM, 8'h01, header byte: load instruction memory.
- CMD_DMEM, 8'h02, header byte: load data memory.
- CMD_RUN, 8'h03, header byte: release core.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts in_data this cycle.
- wr_en  out  1  one-cycle memory write strobe.
- wr_addr  out  ADDR_WIDTH  word address of the write.
- wr_data  out  32  word to write.
- fetch_ram_load  out  1  instruction memory owned by loader; wr_* target imem.
- mem_ram_load  out  1  data memory owned by loader; wr_* target dmem.
- core_hold  out  1  holds the core in reset while high.
- error  out  1  sticky protocol error.

Behaviour:
- Packet format: header byte, count_lo, count_hi (16-bit word count N, little-endian), then N words of 4 bytes each, little-endian. Words are written to addresses 0..N-1.
- A byte transfers only when in_valid && in_ready.
- States: IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERR.
- Reset state: IDLE. All outputs 0 except core_hold=1 and in_ready=1. Word and byte counters cleared.
- IDLE, on transfer:
  - CMD_IMEM or CMD_DMEM: latch target, go to CNT_LO.
  - CMD_RUN: go to RUN.
  - Any other byte: go to ERR.
- CNT_LO: latch low byte of N, go to CNT_HI.
- CNT_HI: latch high byte of N.
  - N==0: return to IDLE. No writes; load flags never rise.
  - N > 2^ADDR_WIDTH: go to ERR.
  - Otherwise: go to DATA and assert the selected load flag (fetch_ram_load or mem_ram_load) from the next cycle.
- DATA: shift bytes into a 32-bit assembly register (byte k goes to bits [8k+7:8k]). On the 4th byte, go to WRITE.
- WRITE: lasts exactly one cycle.
  - in_ready=0, wr_en=1, wr_addr=word index, wr_data=assembled word.
  - Latency: write occurs the cycle after the 4th byte is accepted.
  - Word index increments. If index reaches N, go to IDLE and drop the load flag in that same transition. Otherwise return to DATA.
- Stalls: in_valid gaps are allowed in any state; state holds and no partial word is lost.
- Mutual exclusion: only one load flag is ever high at a time. wr_en is only high while the matching flag is high.
- RUN: core_hold=0, in_ready=0. Further input is ignored. Only reset exits RUN.
- ERR: error=1, in_ready=0, core_hold=1, both load flags 0. Only reset exits ERR.
- Reset asserted mid-packet: next cycle is the reset state. A word already written stays in memory; the partial word is discarded; flags drop immediately.
- Word index width is ADDR_WIDTH+1, so N = 2^ADDR_WIDTH completes without wrap.

Decomposition:
- Shared package riscv_loader_pkg holds:
  - Command constants CMD_IMEM, CMD_DMEM, CMD_RUN.
  - State encoding (typedef for the FSM states).
  - Target enum {TGT_IMEM, TGT_DMEM}.
- One natural sub-module: byte_packer, a 4-byte little-endian assembler with a done pulse. The FSM and counters stay in ram_loader.

Test Plan:
- IMEM load: stream 01 07 00 followed by 7 instruction words (addi x13,x0,3 ... sw x12,8(x0)).
  -> 7 wr_en pulses at addr 0..6 with exact words; fetch_ram_load high throughout; mem_ram_load 0.
- DMEM load then run: 02 02 00 05 00 00 00 07 00 00 00, then 03.
  -> writes dmem[0]=5, dmem[1]=7; core_hold falls one cycle after the 03 byte.
  -> With the core attached, dmem[2]=12 and dmem[3]=3 after execution.
- Back-pressure/gaps: same DMEM packet with in_valid low 3 cycles between every byte.
  -> identical writes; in_ready=0 exactly on each WRITE cycle.
- Zero count: 01 00 00 then 03.
  -> no wr_en, no load flag; core_hold released normally.
- Errors:
  - Header 8'h55 -> error=1, in_ready=0, core_hold stays 1.
  - Count 01 01 04 (N=1025, ADDR_WIDTH=10) -> error=1, no writes.
- Reset mid-load: reset asserted after 2 bytes of word 3 of a 7-word IMEM load.
  -> flags 0 and state IDLE the next cycle; words 0..2 written, no partial write.
  -> A subsequent clean load succeeds.
